pc_fetch_unit: RTL

Program-counter and instruction-fetch block for the single-cycle datapath's front end. It owns the PC register, consumes the next-PC decisions (jump, taken branch, sequential), and issues fetches to instruction memory over a request/grant/response handshake. It presents each fetched instruction with its PC to decode and holds them until decode accepts.

---
 rtl/pc_fetch_pkg.sv | 14 +
 rtl/next_pc_sel.sv | 33 +++
 rtl/pc_fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the PC/fetch front end
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC priority mux: jump > taken branch > sequential
module next_pc_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] jaddr,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_sum;
    logic [31:0] branch_target;
    logic        unused_bits;

    assign jump_target   = {pc_plus4[31:28], jaddr, 2'b00};
    // Word offset scaled to bytes; the top two offset bits fall off the shift.
    assign branch_sum    = pc_plus4 + {branch_offset[29:0], 2'b00};
    assign branch_target = {branch_sum[31:2], 2'b00};
    assign unused_bits   = ^{branch_offset[31:30], branch_sum[1:0]};

    always_comb begin
        next_pc = {pc_plus4[31:2], 2'b00};
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction fetch over req/gnt/rvalid
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump,
    input  logic [25:0] jaddr,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    // imem_addr doubles as the PC register: it only moves on IDLE exit or retire.
    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .jaddr         (jaddr),
        .branch_offset (branch_offset),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            pc_plus4    <= RESET_VECTOR + INSTR_BYTES;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= RESET_VECTOR;
                end
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state       <= HOLD;
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        pc_plus4    <= imem_addr + INSTR_BYTES;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state       <= REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= next_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
